// File: rtl/dsc_mul4_serial.sv
// dsc_mul4_serial: four-operand deterministic stochastic-computing multiplier, serial clock-division form; DSC_SKIP_ZERO_EN makes the inner stages wrap at their operand
module dsc_mul4_serial #(
  parameter int WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic [4*WIDTH-1:0] z,
  output logic               ov
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [WIDTH-1:0] one = 1;
  logic [1:0] state;
  logic [WIDTH-1:0] ra, rb, rc, rd, ca, cb, cc, cd;
  logic [WIDTH-1:0] ca_n, cb_n, cc_n, cd_n;
  logic s, wa, wb, wc, fin, any_zero;
`ifdef DSC_SKIP_ZERO_EN
  assign wa = ca == ra - one;
  assign wb = cb == rb - one;
  assign wc = cc == rc - one;
`else
  assign wa = &ca;
  assign wb = &cb;
  assign wc = &cc;
`endif
  assign ov = state == DONE;
  assign any_zero = ~|a | ~|b | ~|c | ~|d;
  // unary stream bit and nested odometer next values; cd never wraps since it stops at rd
  always_comb begin
    s    = (ca < ra) & (cb < rb) & (cc < rc) & (cd < rd);
    ca_n = wa ? '0 : ca + one;
    cb_n = wa ? (wb ? '0 : cb + one) : cb;
    cc_n = (wa & wb) ? (wc ? '0 : cc + one) : cc;
    cd_n = (wa & wb & wc) ? cd + one : cd;
    fin  = cd_n == rd;
  end
  // start latches operands, RUN accumulates the AND stream until the outer stage reaches rd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      {ra, rb, rc, rd} <= '0;
      {ca, cb, cc, cd} <= '0;
      z <= '0;
    end else if (state == IDLE && en) begin
      {ra, rb, rc, rd} <= {a, b, c, d};
      state <= any_zero ? DONE : RUN;
    end else if (state == RUN && en) begin
      z <= z + {{(4*WIDTH-1){1'b0}}, s};
      {ca, cb, cc, cd} <= {ca_n, cb_n, cc_n, cd_n};
      state <= fin ? DONE : RUN;
    end
  end
endmodule

// File: tb/tb_dsc_mul4_serial.sv
// tb_dsc_mul4_serial: directed checks of the serial DSC multiplier at WIDTH=4
module tb_dsc_mul4_serial;
  logic clk = 0, rst = 1, en = 0;
  logic [3:0] a = 0, b = 0, c = 0, d = 0;
  logic [15:0] z;
  logic ov;
  int checks = 0, fails = 0, n, m;
`ifdef DSC_SKIP_ZERO_EN
  localparam int skip = 1;
`else
  localparam int skip = 0;
`endif
  dsc_mul4_serial #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d), .z(z), .ov(ov));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_ov(input int max, output int cnt);
    cnt = 0;
    while (cnt < max) begin
      @(posedge clk);
      cnt++;
      #1;
      if (ov) break;
    end
  endtask
  task automatic start(input logic [3:0] va, vb, vc, vd);
    @(negedge clk);
    {a, b, c, d} = {va, vb, vc, vd};
    en = 1;
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1;
    en = 0;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_z", z, 0);
    chk("reset_ov", ov, 0);
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_en_ov", ov, 0);
    start(3, 5, 0, 7);
    wait_ov(10, n);
    chk("zero_edges", n, 1);
    chk("zero_z", z, 0);
    @(negedge clk);
    en = 0;
    {a, b, c, d} = {4'd1, 4'd1, 4'd1, 4'd1};
    repeat (3) @(posedge clk);
    #1;
    chk("zero_done_hold", ov, 1);
    do_reset();
    #1;
    chk("rerst_ov", ov, 0);
    start(15, 15, 15, 15);
    wait_ov(70000, n);
    chk("max_edges", n, skip ? 50626 : 61441);
    chk("max_z", z, 50625);
    repeat (5) @(posedge clk);
    #1;
    chk("max_frozen_z", z, 50625);
    chk("max_frozen_ov", ov, 1);
    do_reset();
    start(1, 1, 1, 1);
    repeat (skip ? 1 : 2) @(posedge clk);
    #1;
    chk("pause_pre_z", z, skip ? 0 : 1);
    @(negedge clk);
    en = 0;
    repeat (100) @(posedge clk);
    #1;
    chk("pause_hold_z", z, skip ? 0 : 1);
    chk("pause_hold_ov", ov, 0);
    @(negedge clk);
    en = 1;
    wait_ov(5000, m);
    chk("pause_edges", (skip ? 1 : 2) + 100 + m, skip ? 102 : 4197);
    chk("pause_z", z, 1);
    do_reset();
    start(2, 3, 4, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    {a, b, c, d} = {4'd15, 4'd15, 4'd15, 4'd15};
    wait_ov(5000, m);
    chk("change_edges", 4 + m, skip ? 25 : 4097);
    chk("change_z", z, 24);
    do_reset();
    start(15, 15, 15, 15);
    repeat (11) @(posedge clk);
    #1;
    chk("abort_pre_z", z, 10);
    @(negedge clk);
    #2;
    rst = 1;
    #1;
    chk("abort_z", z, 0);
    chk("abort_ov", ov, 0);
    en = 0;
    @(negedge clk);
    rst = 0;
    start(3, 5, 7, 1);
    wait_ov(5000, n);
    chk("restart_edges", n, skip ? 106 : 4097);
    chk("restart_z", z, 105);
    chk("restart_ov", ov, 1);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
